// File: rtl/spi_dac_receiver.sv
// SPI slave that fills a 16-bit DAC input register (LSB first) and moves it to the DAC code on LDAc.
// Optional SDO readback of input_reg is built only when `SPI_RX_SDO_READBACK_EN is defined.
module spi_dac_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCK,
  input  logic        SDI,
  input  logic        CSn,
  input  logic        LDAc,
  input  logic        CLRn,
  output logic        SDO,
  output logic [15:0] input_reg,
  output logic [15:0] dac_code,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        overrun;

  logic sck_s1, sck_s2, sck_s3;
  logic sdi_s1, sdi_s2, sdi_s3;
  logic csn_s1, csn_s2, csn_s3;
  logic ldac_s1, ldac_s2, ldac_s3;
  logic clrn_s1, clrn_s2, clrn_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1  <= 1'b0; sck_s2  <= 1'b0; sck_s3  <= 1'b0;
      sdi_s1  <= 1'b0; sdi_s2  <= 1'b0; sdi_s3  <= 1'b0;
      csn_s1  <= 1'b1; csn_s2  <= 1'b1; csn_s3  <= 1'b1;
      ldac_s1 <= 1'b1; ldac_s2 <= 1'b1; ldac_s3 <= 1'b1;
      clrn_s1 <= 1'b1; clrn_s2 <= 1'b1; clrn_s3 <= 1'b1;
    end else begin
      sck_s1  <= SCK;  sck_s2  <= sck_s1;  sck_s3  <= sck_s2;
      sdi_s1  <= SDI;  sdi_s2  <= sdi_s1;  sdi_s3  <= sdi_s2;
      csn_s1  <= CSn;  csn_s2  <= csn_s1;  csn_s3  <= csn_s2;
      ldac_s1 <= LDAc; ldac_s2 <= ldac_s1; ldac_s3 <= ldac_s2;
      clrn_s1 <= CLRn; clrn_s2 <= clrn_s1; clrn_s3 <= clrn_s2;
    end
  end

  logic sck_rise, csn_fall, csn_rise, ldac_fall, clr_act, accept;

  assign sck_rise  = sck_s2 & ~sck_s3;
  assign csn_fall  = ~csn_s2 & csn_s3;
  assign csn_rise  = csn_s2 & ~csn_s3;
  assign ldac_fall = ~ldac_s2 & ldac_s3;
  // Clear holds one extra cycle past the CLRn release so both sync stages agree before normal operation resumes.
  assign clr_act   = ~(clrn_s2 & clrn_s3);
  assign accept    = (state == FULL) & csn_rise & ~overrun;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      shift_reg  <= 16'd0;
      overrun    <= 1'b0;
      input_reg  <= 16'd0;
      dac_code   <= 16'd0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (clr_act) begin
        state     <= IDLE;
        bit_cnt   <= 5'd0;
        shift_reg <= 16'd0;
        overrun   <= 1'b0;
        input_reg <= 16'd0;
        dac_code  <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            if (csn_fall) begin
              state     <= SHIFT;
              bit_cnt   <= 5'd0;
              shift_reg <= 16'd0;
              overrun   <= 1'b0;
            end
          end
          SHIFT: begin
            if (csn_rise) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else if (sck_rise) begin
              shift_reg <= {sdi_s3, shift_reg[15:1]};
              bit_cnt   <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) state <= FULL;
            end
          end
          FULL: begin
            if (csn_rise) begin
              if (overrun) begin
                frame_err <= 1'b1;
              end else begin
                input_reg  <= shift_reg;
                word_valid <= 1'b1;
              end
              state <= IDLE;
            end else if (sck_rise) begin
              overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        // A word accepted in this same cycle bypasses input_reg straight into the DAC code.
        if (ldac_fall) dac_code <= accept ? shift_reg : input_reg;
      end
    end
  end

`ifdef SPI_RX_SDO_READBACK_EN
  logic [15:0] rb_reg;
  logic        sck_fall;

  assign sck_fall = ~sck_s2 & sck_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_reg <= 16'd0;
    end else if (csn_fall) begin
      rb_reg <= input_reg;
    end else if (sck_fall && state == SHIFT) begin
      rb_reg <= {1'b0, rb_reg[15:1]};
    end
  end

  assign SDO = rb_reg[0] & ~csn_s2;
`else
  assign SDO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed and randomized frames against a word-level model of the DAC receiver.
module tb_spi_dac_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCK = 1'b0, SDI = 1'b0, CSn = 1'b1, LDAc = 1'b1, CLRn = 1'b1;
  logic        SDO, word_valid, frame_err, busy;
  logic [15:0] input_reg, dac_code;

  int n_pass = 0, n_total = 0;
  int wv_seen = 0, fe_seen = 0, wv_exp = 0, fe_exp = 0;
  logic [15:0] mdl_in = 16'd0, mdl_dac = 16'd0, rb_exp = 16'd0;

  always #5 clk = ~clk;

  spi_dac_receiver dut (
    .clk(clk), .rst(rst), .SCK(SCK), .SDI(SDI), .CSn(CSn), .LDAc(LDAc), .CLRn(CLRn),
    .SDO(SDO), .input_reg(input_reg), .dac_code(dac_code),
    .word_valid(word_valid), .frame_err(frame_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (word_valid) wv_seen++;
    if (frame_err)  fe_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic exp_sdo(input int i);
`ifdef SPI_RX_SDO_READBACK_EN
    return rb_exp[i];
`else
    return 1'b0;
`endif
  endfunction

  task automatic frame_open();
    rb_exp = mdl_in;
    CSn = 1'b0;
    cyc(4);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n, input logic chk_sdo);
    for (int i = 0; i < n; i++) begin
      SDI = d[i];
      cyc(3);
      if (chk_sdo && i < 16) check($sformatf("sdo_bit%0d", i), {31'd0, SDO}, {31'd0, exp_sdo(i)});
      SCK = 1'b1;
      cyc(4);
      SCK = 1'b0;
      cyc(1);
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n, input logic chk_sdo);
    frame_open();
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    send_bits(d, n, chk_sdo);
    cyc(3);
    CSn = 1'b1;
    cyc(6);
    if (n == 16) begin
      mdl_in = d[15:0];
      wv_exp++;
    end else begin
      fe_exp++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_input_reg"}, {16'd0, input_reg}, {16'd0, mdl_in});
    check({tag, "_dac_code"}, {16'd0, dac_code}, {16'd0, mdl_dac});
    check({tag, "_wv_count"}, wv_seen, wv_exp);
    check({tag, "_fe_count"}, fe_seen, fe_exp);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_ldac(input string tag);
    LDAc = 1'b0;
    cyc(4);
    LDAc = 1'b1;
    cyc(5);
    mdl_dac = mdl_in;
    check({tag, "_ldac_dac"}, {16'd0, dac_code}, {16'd0, mdl_dac});
  endtask

  initial begin
    logic        seen;
    logic [31:0] d;
    int          n;

    // Reset state
    cyc(3);
    check("rst_input_reg", {16'd0, input_reg}, 32'd0);
    check("rst_dac_code", {16'd0, dac_code}, 32'd0);
    check("rst_pulses", {30'd0, word_valid, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sdo", {31'd0, SDO}, 32'd0);
    rst = 1'b0;
    cyc(3);

    // Basic word, DAC code held until LDAc
    send_frame(32'h0000_A5C3, 16, 1'b0);
    check_state("a5c3");
    pulse_ldac("a5c3");

    // Readback of a known input_reg during the next frame
    send_frame(32'h0000_8001, 16, 1'b0);
    check_state("w8001");
    send_frame(32'h0000_3C5A, 16, 1'b1);
    check("sdo_idle", {31'd0, SDO}, 32'd0);
    check_state("rb_frame");

    // Short and long frames
    send_frame(32'h0000_1111, 15, 1'b0);
    check_state("short15");
    send_frame(32'h0001_2222, 17, 1'b0);
    check_state("long17");

    // Word acceptance coinciding with LDAc fall
    frame_open();
    send_bits(32'h0000_1234, 16, 1'b0);
    cyc(3);
    CSn = 1'b1;
    LDAc = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (word_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("coin_wv_seen", {31'd0, seen}, 32'd1);
    check("coin_dac_same_cycle", {16'd0, dac_code}, 32'h1234);
    wv_exp++;
    mdl_in = 16'h1234;
    cyc(3);
    LDAc = 1'b1;
    cyc(5);
    mdl_dac = 16'h1234;
    check_state("coin");

    // CLRn mid-frame
    frame_open();
    send_bits(32'h0000_00AB, 8, 1'b0);
    CLRn = 1'b0;
    cyc(5);
    check("clr_input_reg", {16'd0, input_reg}, 32'd0);
    check("clr_dac_code", {16'd0, dac_code}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    CSn = 1'b1;
    cyc(5);
    CLRn = 1'b1;
    cyc(6);
    mdl_in = 16'd0;
    mdl_dac = 16'd0;
    check_state("clr");
    send_frame(32'h0000_00FF, 16, 1'b0);
    check_state("after_clr");
    pulse_ldac("after_clr");

    // Reset mid-frame
    frame_open();
    send_bits(32'h0000_0155, 10, 1'b0);
    rst = 1'b1;
    cyc(2);
    CSn = 1'b1;
    SDI = 1'b0;
    cyc(2);
    check("mrst_input_reg", {16'd0, input_reg}, 32'd0);
    check("mrst_dac_code", {16'd0, dac_code}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_sdo", {31'd0, SDO}, 32'd0);
    rst = 1'b0;
    cyc(6);
    mdl_in = 16'd0;
    mdl_dac = 16'd0;
    check_state("mrst");
    send_frame(32'h0000_FFFF, 16, 1'b0);
    check_state("after_rst");
    pulse_ldac("after_rst");

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      d = $urandom;
      n = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(14, 18));
      send_frame(d, n, 1'b1);
      check_state($sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) pulse_ldac($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
